// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the E stage.
// Owns HI/LO, computes the result at launch into pending registers and
// commits it after a fixed busy period so the hazard unit sees a
// deterministic latency.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        Req,
    output logic        start,
    output logic        busy,
    output logic [31:0] dataout,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     hi_pend_q;
    logic [31:0]     lo_pend_q;

    logic            is_mul_s;
    logic            is_div_s;
    logic            is_signed_s;
    logic            launch_s;
    logic [63:0]     a_ext_s;
    logic [63:0]     b_ext_s;
    logic [63:0]     prod_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [31:0]     a_mag_s;
    logic [31:0]     b_mag_s;
    logic [31:0]     b_safe_s;
    logic [31:0]     q_mag_s;
    logic [31:0]     r_mag_s;
    logic [31:0]     quo_s;
    logic [31:0]     rem_s;
    logic [31:0]     hi_pend_d;
    logic [31:0]     lo_pend_d;

    // Decode the E-stage op into launch controls.
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (op)
            4'd1: begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
            4'd2: begin is_mul_s = 1'b1; is_signed_s = 1'b0; end
            4'd3: begin is_div_s = 1'b1; is_signed_s = 1'b1; end
            4'd4: begin is_div_s = 1'b1; is_signed_s = 1'b0; end
            default: begin is_mul_s = 1'b0; is_div_s = 1'b0; is_signed_s = 1'b0; end
        endcase
        launch_s = (state_q == ST_IDLE) && (is_mul_s || is_div_s) && !Req;
    end

    // Result datapath: one 64-bit multiplier for both signednesses (the
    // low 64 bits of a sign/zero-extended product are exact), and a
    // magnitude divider with sign fix-up so quotient truncates to zero and
    // the remainder follows the dividend.
    always_comb begin
        a_ext_s  = {{32{is_signed_s & dataA[31]}}, dataA};
        b_ext_s  = {{32{is_signed_s & dataB[31]}}, dataB};
        prod_s   = a_ext_s * b_ext_s;

        a_neg_s  = is_signed_s & dataA[31];
        b_neg_s  = is_signed_s & dataB[31];
        a_mag_s  = a_neg_s ? (32'd0 - dataA) : dataA;
        b_mag_s  = b_neg_s ? (32'd0 - dataB) : dataB;
        // Divider never sees zero; the zero-divisor case keeps HI/LO anyway.
        b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        q_mag_s  = a_mag_s / b_safe_s;
        r_mag_s  = a_mag_s % b_safe_s;
        quo_s    = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s    = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

        if (is_mul_s) begin
            hi_pend_d = prod_s[63:32];
            lo_pend_d = prod_s[31:0];
        end else if (is_div_s && (dataB != 32'd0)) begin
            hi_pend_d = rem_s;
            lo_pend_d = quo_s;
        end else begin
            // Divide by zero (or no op): committing current values is a no-op.
            hi_pend_d = hi_q;
            lo_pend_d = lo_q;
        end
    end

    // Sequencer FSM with counter, busy flag and HI/LO ownership.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch_s) begin
                        hi_pend_q <= hi_pend_d;
                        lo_pend_q <= lo_pend_d;
                        busy_q    <= 1'b1;
                        if (is_mul_s) begin
                            cnt_q   <= CW'(MULT_CYCLES);
                            state_q <= ST_MUL;
                        end else begin
                            cnt_q   <= CW'(DIV_CYCLES);
                            state_q <= ST_DIV;
                        end
                    end else if (!Req && (op == 4'd7)) begin
                        hi_q <= dataA;
                    end else if (!Req && (op == 4'd8)) begin
                        lo_q <= dataA;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= hi_pend_q;
                        lo_q    <= lo_pend_q;
                        busy_q  <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CW{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Move-from read port: shows committed HI/LO only.
    always_comb begin
        case (op)
            4'd5:    dataout = hi_q;
            4'd6:    dataout = lo_q;
            default: dataout = 32'd0;
        endcase
    end

    assign start = launch_s;
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
